// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle control FSM and the MIPS datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             alu_zero;
    logic             mem_ready;
    logic             run;
    logic             halt_req;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, alu_zero, mem_ready, run, halt_req,
        output pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write, reg_dst,
        output mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
        output state, illegal, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, alu_zero, mem_ready, run, halt_req,
        input  pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write, reg_dst,
        input  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
        input  state, illegal, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: registered state decoded into datapath selects/enables,
// memory handshake on mem_ready, run/halt at instruction boundaries, illegal-opcode trap.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StMemAdr = 4'd3;
    localparam logic [3:0] StMemRd  = 4'd4;
    localparam logic [3:0] StMemWb  = 4'd5;
    localparam logic [3:0] StMemWr  = 4'd6;
    localparam logic [3:0] StExec   = 4'd7;
    localparam logic [3:0] StRwb    = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;
    localparam logic [3:0] StJump   = 4'd10;
    localparam logic [3:0] StAddiEx = 4'd11;
    localparam logic [3:0] StAddiWb = 4'd12;
    localparam logic [3:0] StTrap   = 4'd13;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            StIdle:   if (bus.run) state_d = StFetch;
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWr:  retire = bus.mem_ready;
            StExec:   state_d = StRwb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StRwb, StBranch, StJump, StAddiWb: retire = 1'b1;
            StTrap:   state_d = StTrap;
            default:  state_d = StIdle;
        endcase
        // halt_req only matters on the cycle an instruction retires
        if (retire) state_d = bus.halt_req ? StIdle : StFetch;
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != StIdle && state_q != StTrap) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (retire) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            illegal_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        case (state_q)
            StFetch: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            StDecode: bus.alu_src_b = 2'b11;
            StMemAdr, StAddiEx: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            StMemRd: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            StExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            StRwb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StBranch: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            StJump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            StAddiWb: bus.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state/controls go through a
// scoreboard queue; narrow counters (CNT_W=4) so the cycle counter wraps during the run.
module tb_multicycle_ctrl;
    localparam int unsigned W = 4;

    typedef struct {
        int         idx;
        logic [3:0] st;
        logic [15:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;
    exp_t sb[$];
    logic [W-1:0] exp_cyc = '0;
    logic [W-1:0] exp_ins = '0;
    logic         exp_ill = 1'b0;

    multicycle_ctrl_if #(.CNT_W(W)) bus ();
    multicycle_ctrl #(.CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] obs_ctrl;
    assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_rd, bus.mem_wr,
                       bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_op, bus.pc_source};

    // Expected control word for a state, straight from the control table.
    function automatic logic [15:0] ctrl_of(input logic [3:0] s, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
        {asb, aop, psrc} = '0;
        case (s)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; iord = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            4'd10: begin pcw = 1; psrc = 2'b10; end
            4'd11: begin asa = 1; asb = 2'b10; end
            4'd12: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    // One clock: queue what this cycle must show, compare at negedge, advance the model.
    task automatic step(input logic [3:0] st);
        exp_t e;
        sb.push_back('{idx: step_no, st: st, ctrl: ctrl_of(st, bus.mem_ready)});
        @(negedge clk);
        if (st == 4'd13) exp_ill = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("state", 32'(bus.state), 32'(e.st));
            chk("ctrl", 32'(obs_ctrl), 32'(e.ctrl));
        end
        chk("illegal", 32'(bus.illegal), 32'(exp_ill));
        chk("cycle_cnt", 32'(bus.cycle_cnt), 32'(exp_cyc));
        chk("instr_cnt", 32'(bus.instr_cnt), 32'(exp_ins));
        if (st != 4'd0 && st != 4'd13) exp_cyc = exp_cyc + 1'b1;
        if (st == 4'd5 || st == 4'd8 || st == 4'd9 || st == 4'd10 || st == 4'd12 ||
            (st == 4'd6 && bus.mem_ready)) exp_ins = exp_ins + 1'b1;
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_ctrl", 32'(obs_ctrl), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_cyc", 32'(bus.cycle_cnt), 32'd0);
        chk("rst_ins", 32'(bus.instr_cnt), 32'd0);
        exp_cyc = '0;
        exp_ins = '0;
        exp_ill = 1'b0;
    endtask

    initial begin
        bus.opcode = 6'h00; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
        bus.run = 1'b0; bus.halt_req = 1'b0;
        #12;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type
        bus.run = 1'b1;
        step(4'd0);
        step(4'd1); step(4'd2); step(4'd7); step(4'd8);
        // lw with fetch and read waits
        bus.opcode = 6'h23; bus.mem_ready = 1'b0;
        step(4'd1); step(4'd1);
        bus.mem_ready = 1'b1;
        step(4'd1); step(4'd2); step(4'd3);
        bus.mem_ready = 1'b0;
        step(4'd4); step(4'd4); step(4'd4);
        bus.mem_ready = 1'b1;
        step(4'd4); step(4'd5);
        // beq taken, then not taken
        bus.opcode = 6'h04; bus.alu_zero = 1'b1;
        step(4'd1); step(4'd2); step(4'd9);
        bus.alu_zero = 1'b0;
        step(4'd1); step(4'd2); step(4'd9);
        // addi, j
        bus.opcode = 6'h08;
        step(4'd1); step(4'd2); step(4'd11); step(4'd12);
        bus.opcode = 6'h02;
        step(4'd1); step(4'd2); step(4'd10);
        // sw with halt held; one write wait cycle first
        bus.opcode = 6'h2B; bus.halt_req = 1'b1;
        step(4'd1); step(4'd2); step(4'd3);
        bus.mem_ready = 1'b0;
        step(4'd6);
        bus.mem_ready = 1'b1;
        step(4'd6);
        bus.run = 1'b0; bus.halt_req = 1'b0;
        step(4'd0); step(4'd0); step(4'd0);
        // illegal opcode traps until reset
        bus.run = 1'b1; bus.opcode = 6'h3F;
        step(4'd0); step(4'd1); step(4'd2);
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) step(4'd13);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;
        // async reset in the middle of a memory read
        bus.run = 1'b1; bus.opcode = 6'h23;
        step(4'd0); step(4'd1); step(4'd2); step(4'd3);
        bus.mem_ready = 1'b0;
        step(4'd4);
        chk("memrd_before_rst", 32'(bus.mem_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check_reset_state();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "timeout");
    end
endmodule
